// File: rtl/mux_tree_pipe_if.sv
// Handshake bundle for mux_tree_pipe: word set + select in, one selected word out.
// The slave modport is the mux tree; master is the producer/consumer side.
interface mux_tree_pipe_if #(
  parameter int N_IN = 8,
  parameter int DW   = 1
);
  localparam int SW = $clog2(N_IN);

  logic              in_valid;
  logic              in_ready;
  logic [SW-1:0]     s;
  logic [N_IN*DW-1:0] d;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out;

  modport slave (
    input  in_valid, s, d, out_ready,
    output in_ready, out_valid, out
  );

  modport master (
    output in_valid, s, d, out_ready,
    input  in_ready, out_valid, out
  );
endinterface

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 mux tree, one register per 2:1 level; MUX_TREE_PIPE_ZERO_EN forces out to 0 while idle.
// Latency log2(N_IN) cycles, 1 word/cycle; in_ready combinational from out_ready.
// Backpressure: per-stage ready chain, empty stages keep advancing so bubbles collapse.
module mux_tree_pipe #(
  parameter  int N_IN = 8,
  parameter  int DW   = 1,
  localparam int SW   = $clog2(N_IN)
) (
  input logic          clk,
  input logic          rst,
  mux_tree_pipe_if.slave bus
);

  localparam int L = SW;

  for (genvar i = 1; i <= L; i++) begin : stg
    localparam int NW = N_IN >> i;

    logic [NW*DW-1:0]   dat;
    logic [NW*DW-1:0]   nxt;
    logic [2*NW*DW-1:0] up_dat;
    logic               up_vld;
    logic               up_bit;
    logic               v;
    logic               adv;
    logic               dn_adv;

    if (i == 1) begin : g_up
      assign up_dat = bus.d;
      assign up_vld = bus.in_valid;
      assign up_bit = bus.s[0];
    end else begin : g_up
      assign up_dat = stg[i-1].dat;
      assign up_vld = stg[i-1].v;
      assign up_bit = stg[i-1].g_sel.sel[0];
    end

    if (i == L) begin : g_dn
      assign dn_adv = bus.out_ready;
    end else begin : g_dn
      assign dn_adv = stg[i+1].adv;
    end

    // An empty stage always advances, regardless of what is downstream.
    assign adv = ~v | dn_adv;

    always_comb begin
      nxt = '0;
      for (int j = 0; j < NW; j++) begin
        nxt[j*DW +: DW] = up_bit ? up_dat[(2*j+1)*DW +: DW] : up_dat[2*j*DW +: DW];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v   <= 1'b0;
        dat <= '0;
      end else if (adv) begin
        v <= up_vld;
`ifdef MUX_TREE_PIPE_ZERO_EN
        if (up_vld) begin
          dat <= nxt;
        end
`else
        dat <= nxt;
`endif
      end
    end

    // Remaining select bits travel with their data; the last stage needs none.
    if (i < L) begin : g_sel
      logic [SW-i-1:0] sel;
      logic [SW-i-1:0] up_sel;

      if (i == 1) begin : g_src
        assign up_sel = bus.s[SW-1:1];
      end else begin : g_src
        assign up_sel = stg[i-1].g_sel.sel[SW-i:1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sel <= '0;
        end else if (adv) begin
`ifdef MUX_TREE_PIPE_ZERO_EN
          if (up_vld) begin
            sel <= up_sel;
          end
`else
          sel <= up_sel;
`endif
        end
      end
    end
  end

  assign bus.in_ready  = stg[1].adv;
  assign bus.out_valid = stg[L].v;

`ifdef MUX_TREE_PIPE_ZERO_EN
  assign bus.out = stg[L].v ? stg[L].dat : '0;
`else
  assign bus.out = stg[L].dat;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: 8:1 x 4-bit instance plus a 2:1 x 8-bit instance.
module tb_mux_tree_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux_tree_pipe_if #(.N_IN(8), .DW(4)) b8 ();
  mux_tree_pipe_if #(.N_IN(2), .DW(8)) b2 ();

  mux_tree_pipe #(.N_IN(8), .DW(4)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  mux_tree_pipe #(.N_IN(2), .DW(8)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_vld8 got %b exp 0", b8.out_valid); end
    checks++; if (b8.out !== 4'h0) begin errors++; $display("FAIL reset_out8 got %h exp 0", b8.out); end
    checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy8 got %b exp 1", b8.in_ready); end
    checks++; if (b2.out_valid !== 1'b0 || b2.out !== 8'h00) begin
      errors++; $display("FAIL reset_n2 got vld %b out %h exp 0 00", b2.out_valid, b2.out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic exp_v;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      b8.in_valid  = (c == 0);
      b8.s         = 3'd5;
      b8.out_ready = 1'b1;
      @(negedge clk);
      exp_v = (c == 3);
      checks++; if (b8.out_valid !== exp_v) begin errors++; $display("FAIL single_vld c=%0d got %b exp %b", c, b8.out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (b8.out !== 4'h5) begin errors++; $display("FAIL single_out got %h exp 5", b8.out); end
      end
    end
  endtask

  task automatic test_stream();
    logic       exp_v;
    logic [3:0] exp_o;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      b8.in_valid  = (c < 8);
      b8.s         = 3'(c);
      b8.out_ready = 1'b1;
      @(negedge clk);
      exp_v = (c >= 3 && c <= 10);
      exp_o = 4'(c - 3);
      checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL stream_rdy c=%0d got %b exp 1", c, b8.in_ready); end
      checks++; if (b8.out_valid !== exp_v) begin errors++; $display("FAIL stream_vld c=%0d got %b exp %b", c, b8.out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (b8.out !== exp_o) begin errors++; $display("FAIL stream_out c=%0d got %h exp %h", c, b8.out, exp_o); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic       exp_v;
    logic       exp_r;
    logic [3:0] exp_o;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      b8.in_valid  = (c < 3);
      b8.s         = 3'(c + 1);
      b8.out_ready = (c >= 6);
      @(negedge clk);
      exp_r = !(c >= 3 && c <= 5);
      exp_v = (c >= 3 && c <= 8);
      exp_o = (c <= 6) ? 4'h1 : 4'(c - 5);
      checks++; if (b8.in_ready !== exp_r) begin errors++; $display("FAIL bp_rdy c=%0d got %b exp %b", c, b8.in_ready, exp_r); end
      checks++; if (b8.out_valid !== exp_v) begin errors++; $display("FAIL bp_vld c=%0d got %b exp %b", c, b8.out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (b8.out !== exp_o) begin errors++; $display("FAIL bp_out c=%0d got %h exp %h", c, b8.out, exp_o); end
      end
    end
  endtask

  task automatic test_bubble();
    logic       exp_v;
    logic [3:0] exp_o;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      b8.in_valid  = (c == 0) || (c == 3);
      b8.s         = (c == 0) ? 3'd2 : 3'd4;
      b8.out_ready = (c >= 5);
      @(negedge clk);
      exp_v = (c >= 3 && c <= 6);
      exp_o = (c <= 5) ? 4'h2 : 4'h4;
      checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL bubble_rdy c=%0d got %b exp 1", c, b8.in_ready); end
      checks++; if (b8.out_valid !== exp_v) begin errors++; $display("FAIL bubble_vld c=%0d got %b exp %b", c, b8.out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (b8.out !== exp_o) begin errors++; $display("FAIL bubble_out c=%0d got %h exp %h", c, b8.out, exp_o); end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic exp_v;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      b8.in_valid  = 1'b1;
      b8.s         = 3'(c + 1);
      b8.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    checks++; if (b8.out_valid !== 1'b1 || b8.out !== 4'h1) begin
      errors++; $display("FAIL pre_rst got vld %b out %h exp 1 1", b8.out_valid, b8.out);
    end
    rst = 1'b1;
    #1;
    checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_vld got %b exp 0", b8.out_valid); end
    checks++; if (b8.out !== 4'h0) begin errors++; $display("FAIL async_rst_out got %h exp 0", b8.out); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      b8.in_valid = (c == 0);
      b8.s        = 3'd6;
      @(negedge clk);
      exp_v = (c == 3);
      checks++; if (b8.out_valid !== exp_v) begin errors++; $display("FAIL post_rst_vld c=%0d got %b exp %b", c, b8.out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (b8.out !== 4'h6) begin errors++; $display("FAIL post_rst_out got %h exp 6", b8.out); end
      end
    end
  endtask

  task automatic test_n2();
    logic       exp_v;
    logic [7:0] exp_o;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      b2.in_valid  = (c < 2);
      b2.s         = (c == 0) ? 1'b1 : 1'b0;
      b2.out_ready = 1'b1;
      @(negedge clk);
      exp_v = (c == 1) || (c == 2);
      exp_o = (c == 1) ? 8'hAB : 8'hCD;
      checks++; if (b2.out_valid !== exp_v) begin errors++; $display("FAIL n2_vld c=%0d got %b exp %b", c, b2.out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (b2.out !== exp_o) begin errors++; $display("FAIL n2_out c=%0d got %h exp %h", c, b2.out, exp_o); end
      end
`ifdef MUX_TREE_PIPE_ZERO_EN
      if (!exp_v) begin
        checks++; if (b2.out !== 8'h00) begin errors++; $display("FAIL n2_idle_zero c=%0d got %h exp 00", c, b2.out); end
      end
`endif
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    b8.in_valid  = 1'b0;
    b8.s         = '0;
    b8.d         = 32'h7654_3210;
    b8.out_ready = 1'b1;
    b2.in_valid  = 1'b0;
    b2.s         = '0;
    b2.d         = 16'hABCD;
    b2.out_ready = 1'b1;

    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_bubble();
    test_mid_reset();
    test_n2();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
